// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line/frame counters, syncs, blanking, sticky IRQ flags.
// Latency: counters and flags update on the clk edge of a ce cycle; syncs lag counters by one ce step.
// Backpressure: none; ce=0 freezes the raster (only cli still acts on the flags).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 104,
  parameter int H_BP      = 152,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 1,
  parameter int XW        = 11,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [YW-1:0] line_cmp,
  input  logic          en_vblank,
  input  logic          en_line,
  input  logic          cli,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [7:0]    frame,
  output logic          st_vblank,
  output logic          st_line,
  output logic          irq
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_VBLANK = YW'(V_ACTIVE);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    frame_q, frame_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          stv_q, stv_d;
  logic          stl_q, stl_d;
  logic          wrap;
  logic          set_v;
  logic          set_l;

  // Next raster position, syncs from the pre-update position, and flag set/clear.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    wrap    = 1'b0;
    if (ce) begin
      hs_d = (32'(x_q) >= HS_START && 32'(x_q) < HS_END) ? HS_ON : ~HS_ON;
      vs_d = (32'(y_q) >= VS_START && 32'(y_q) < VS_END) ? VS_ON : ~VS_ON;
      if (x_q == X_LAST) begin
        x_d  = '0;
        wrap = 1'b1;
        if (y_q == Y_LAST) begin
          y_d     = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // Only a line wrap can land on x=0, so the events are qualified by wrap.
    // y_d never exceeds V_TOTAL-1, so an out-of-range line_cmp never matches.
    set_v = wrap && (y_d == Y_VBLANK);
    set_l = wrap && (y_d == line_cmp);
    // A set event beats a simultaneous cli so no event is lost.
    stv_d = set_v | (stv_q & ~cli);
    stl_d = set_l | (stl_q & ~cli);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      stv_q   <= 1'b0;
      stl_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      stv_q   <= stv_d;
      stl_q   <= stl_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign frame     = frame_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign st_vblank = stv_q;
  assign st_line   = stl_q;
  assign blank     = (32'(x_q) >= H_ACTIVE) | (32'(y_q) >= V_ACTIVE);
  assign irq       = (stv_q & en_vblank) | (stl_q & en_line);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen in small-mode geometry (14x7 raster, inverted syncs).
// Every step pushes the modelled post-edge outputs to a scoreboard and pops/compares after the edge.
// Directed constant checks cover reset values, sync widths, frame length and flag corner cases.
module tb_vga_timing_gen;

  localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
  localparam int HT  = H_A + H_F + H_S + H_B;   // 14
  localparam int VT  = V_A + V_F + V_S + V_B;   // 7
  localparam logic HP = 1'b1;
  localparam logic VP = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [2:0] line_cmp = 3'd0;
  logic       en_vblank = 1'b0;
  logic       en_line = 1'b0;
  logic       cli = 1'b0;
  logic [3:0] x;
  logic [2:0] y;
  logic       hsync, vsync, blank, st_vblank, st_line, irq;
  logic [7:0] frame;

  vga_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HSYNC_POL(1), .VSYNC_POL(0), .XW(4), .YW(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .line_cmp(line_cmp),
    .en_vblank(en_vblank), .en_line(en_line), .cli(cli),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank(blank),
    .frame(frame), .st_vblank(st_vblank), .st_line(st_line), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] fr;
    logic       sv;
    logic       sl;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state
  int   mx = 0, my = 0, mf = 0;
  logic mhs = ~HP, mvs = ~VP, msv = 1'b0, msl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Drive one clk cycle: model the edge, push expectation, then pop and compare after it.
  task automatic step(input logic ce_v, input logic cli_v, input logic rst_v);
    exp_t e;
    logic setv, setl;
    ce = ce_v; cli = cli_v; rst_n = rst_v;
    setv = 1'b0; setl = 1'b0;
    if (!rst_v) begin
      mx = 0; my = 0; mf = 0; mhs = ~HP; mvs = ~VP; msv = 1'b0; msl = 1'b0;
    end else begin
      if (ce_v) begin
        mhs = (mx >= H_A + H_F && mx < H_A + H_F + H_S) ? HP : ~HP;
        mvs = (my >= V_A + V_F && my < V_A + V_F + V_S) ? VP : ~VP;
        if (mx == HT - 1) begin
          mx = 0;
          if (my == VT - 1) begin my = 0; mf = (mf + 1) % 256; end
          else my = my + 1;
          setv = (my == V_A);
          setl = (my == int'(line_cmp));
        end else begin
          mx = mx + 1;
        end
      end
      if (setv) msv = 1'b1; else if (cli_v) msv = 1'b0;
      if (setl) msl = 1'b1; else if (cli_v) msl = 1'b0;
    end
    e.x  = 4'(mx);
    e.y  = 3'(my);
    e.hs = mhs;
    e.vs = mvs;
    e.bl = (mx >= H_A) || (my >= V_A);
    e.fr = 8'(mf);
    e.sv = msv;
    e.sl = msl;
    e.irq = (msv & en_vblank) | (msl & en_line);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("x", 32'(x), 32'(e.x));
    chk("y", 32'(y), 32'(e.y));
    chk("hsync", 32'(hsync), 32'(e.hs));
    chk("vsync", 32'(vsync), 32'(e.vs));
    chk("blank", 32'(blank), 32'(e.bl));
    chk("frame", 32'(frame), 32'(e.fr));
    chk("st_vblank", 32'(st_vblank), 32'(e.sv));
    chk("st_line", 32'(st_line), 32'(e.sl));
    chk("irq", 32'(irq), 32'(e.irq));
  endtask

  initial begin
    int hs_cnt, vs_cnt, sl_seen, irq_seen, blank_x;

    // Reset with ce=1: outputs sit at their reset values.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // First frame: line_cmp=2, both enables on.
    line_cmp = 3'd2; en_vblank = 1'b1; en_line = 1'b1;
    hs_cnt = 0; vs_cnt = 0; blank_x = -1;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i < HT && hsync === 1'b1) hs_cnt++;
      if (i < HT && blank_x < 0 && blank === 1'b1) blank_x = int'(x);
      if (vsync === 1'b0) vs_cnt++;
      if (i == HT * V_A - 1) chk("vblank_set_at_y4", 32'(st_vblank), 32'd1);
    end
    chk("hsync_width", 32'(hs_cnt), 32'd2);
    chk("blank_first_x", 32'(blank_x), 32'd8);
    chk("vsync_width", 32'(vs_cnt), 32'(HT));
    chk("frame_after_98", 32'(frame), 32'd1);
    chk("pos_after_frame", 32'({x, 1'b0, y}), 32'd0);

    // cli on the exact cycle the raster reaches (0,2): set wins.
    for (int i = 0; i < 2 * HT - 1; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("cli_vs_set_st_line", 32'(st_line), 32'd1);
    chk("cli_vs_set_irq", 32'(irq), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("cli_clear_st_line", 32'(st_line), 32'd0);
    chk("cli_clear_st_vblank", 32'(st_vblank), 32'd0);
    chk("cli_clear_irq", 32'(irq), 32'd0);

    // line_cmp out of range, vblank irq disabled: two frames.
    line_cmp = 3'd7; en_vblank = 1'b0; en_line = 1'b1;
    sl_seen = 0; irq_seen = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (st_line !== 1'b0) sl_seen++;
      if (irq !== 1'b0) irq_seen++;
    end
    chk("oob_st_line_never", 32'(sl_seen), 32'd0);
    chk("oob_irq_never", 32'(irq_seen), 32'd0);
    chk("oob_st_vblank_set", 32'(st_vblank), 32'd1);
    chk("frame_after_3", 32'(frame), 32'd3);

    // ce toggling: one line takes 2*HT clk cycles.
    for (int i = 0; i < 2 * HT; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
    chk("ce_line_x", 32'(x), 32'd1);
    chk("ce_line_y", 32'(y), 32'd3);
    step(1'b0, 1'b1, 1'b1);
    chk("cli_ce0_st_vblank", 32'(st_vblank), 32'd0);
    chk("cli_ce0_x_hold", 32'(x), 32'd1);

    // Mid-frame reset, then restart from (0,0).
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_frame", 32'(frame), 32'd0);
    chk("midrst_syncs", 32'({hsync, vsync}), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    chk("restart_x", 32'(x), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next-generation replacement for the fixed 1024x768 timing block in the VGA console peripheral. It produces pixel/line counters, sync pulses with configurable polarity, a blanking flag, a frame counter and two sticky interrupt sources: start-of-vblank and a programmable raster-line compare. A clock-enable input lets one design serve pixel clocks that are integer divisions of `clk`.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 48, horizontal front porch (pixels)
- `H_SYNC`, 104, hsync width (pixels)
- `H_BP`, 152, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 4, vsync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HSYNC_POL`, 0, active level of `hsync` (0 = active-low)
- `VSYNC_POL`, 1, active level of `vsync` (1 = active-high)
- `XW`, 11, width of `x`; must hold H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
- `YW`, 10, width of `y` and `line_cmp`; must hold V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, synchronous, active-low
- `ce` in 1: pixel enable; counters advance only on cycles with `ce`=1
- `line_cmp` in YW: raster-compare line number
- `en_vblank` in 1: enable vblank interrupt onto `irq`
- `en_line` in 1: enable line-compare interrupt onto `irq`
- `cli` in 1: one-cycle pulse that clears both sticky flags
- `x` out XW: current pixel column
- `y` out YW: current line
- `hsync` out 1: horizontal sync, registered
- `vsync` out 1: vertical sync, registered
- `blank` out 1: 1 outside the active area, combinational from `x`/`y`
- `frame` out 8: frame counter
- `st_vblank` out 1: sticky vblank flag
- `st_line` out 1: sticky line-compare flag
- `irq` out 1: (`st_vblank` & `en_vblank`) | (`st_line` & `en_line`)

## Operation
Counters:
- On a `ce` cycle, `x` increments. At `x`=H_TOTAL-1, `x` goes to 0 and `y` increments.
- At (`x`=H_TOTAL-1, `y`=V_TOTAL-1), `x` and `y` both go to 0 and `frame` increments. `frame` wraps 255 to 0.
- When `ce`=0, every register holds, except that `cli` still clears the flags.

Syncs and blanking:
- `hsync` is asserted at level HSYNC_POL while H_ACTIVE+H_FP <= `x` < H_ACTIVE+H_FP+H_SYNC. Otherwise it is at !HSYNC_POL.
- `vsync` is asserted at level VSYNC_POL while V_ACTIVE+V_FP <= `y` < V_ACTIVE+V_FP+V_SYNC. Otherwise it is at !VSYNC_POL.
- `blank` = (`x` >= H_ACTIVE) | (`y` >= V_ACTIVE).

Flags:
- `st_vblank` sets on the `ce` cycle whose counter update produces (`x`=0, `y`=V_ACTIVE).
- `st_line` sets on the `ce` cycle whose update produces (`x`=0, `y`=`line_cmp`). `line_cmp` is sampled on that cycle.
- If `line_cmp` >= V_TOTAL, `st_line` never sets.
- A set event and `cli` in the same cycle: set wins, so the flag ends at 1. No event is lost.
- Flags stay set until `cli`, including across frames.
- `en_*` gate only `irq`, never the flags.

Reset values:
- `x`=0, `y`=0, `frame`=0, `st_vblank`=0, `st_line`=0.
- `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL.
- `irq`=0 and `blank`=0 (both follow from the above).
- Reset mid-frame restarts the raster at (0,0) on the next cycle. No partial-frame flag is raised.

## Timing
- `x`, `y`, `frame` and the flags update on the `clk` edge of a `ce` cycle.
- `hsync`/`vsync` are registered from the pre-update `x`/`y` on `ce` cycles, so they lag the counter state by one `ce` step. This matches one pipeline stage of pixel fetch downstream.
- `blank` has zero latency relative to `x`/`y`.
- `irq` is combinational from the flags and enables: it rises in the same cycle as the flag becomes 1.
- `cli` takes effect on the next edge, whatever the value of `ce`.
- Line length is H_TOTAL `ce` cycles. Frame length is H_TOTAL*V_TOTAL `ce` cycles; with defaults that is 1328*798 = 1,059,744.

## Test plan
- Reset release with `ce`=1 and defaults:
  - `x` runs 0..1327 and wraps; `y` increments at each wrap.
  - `hsync` is low for exactly 104 cycles, starting one cycle after `x`=1072.
  - `blank` goes 1 at `x`=1024.
- Full frame with defaults:
  - `vsync` is high for 4 lines, from `y`=771 through 774 (lagged one cycle).
  - `frame` goes 0→1 at the (1327,797)→(0,0) transition.
  - `st_vblank` sets when `y` becomes 768 with `x`=0.
- `line_cmp`=100, `en_line`=1: `st_line` and `irq` rise when (0,100) is reached. Pulse `cli` → both clear next cycle. Also drive `cli` on exactly the set cycle → flag stays 1.
- `line_cmp`=900 (>= V_TOTAL): over two frames `st_line` stays 0. With `en_vblank`=0, `irq` stays 0 while `st_vblank` still sets.
- `ce` toggling 1,0,1,0: `x` advances every other cycle, and line length is 2656 `clk` cycles. `cli` during a `ce`=0 cycle still clears the flags.
- Small-mode parameters (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1, VSYNC_POL=0, XW=4, YW=3):
  - frame = 14*7 = 98 cycles;
  - sync polarities are inverted;
  - asserting `rst_n`=0 mid-frame returns all outputs to their reset values on the next edge.
